stack_cpu_controller: RTL and testbench
=======================================

STACK_CPU_CONTROLLER -- requirements
Module: stack_cpu_controller

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 clk  input  1  single clock; all state changes occur on the rising edge.
REQ-003 rst  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 opcode  input  3  instruction opcode IR[7:5] from the datapath; stable from the cycle after FETCH until the next FETCH.
REQ-005 pcWrite, pcWriteCond, pcSrc, IorD  output  1 each  PC load (unconditional), PC load gated by zero, PC source (0 = ALU, 1 = IR[4:0]), memory address source (0 = PC, 1 = IR[4:0]).
REQ-006 memRead, memWrite, IRWrite, MtoS  output  1 each  memory read, memory write, IR load, stack input source (0 = ALU register, 1 = MDR).
REQ-007 ldA, ldB, srcA, srcB  output  1 each  load A, load B, ALU A source (0 = A, 1 = PC), ALU B source (0 = B, 1 = constant 1).
REQ-008 push, pop, tos  output  1 each  stack push, stack pop, stack top-of-stack read.
REQ-009 ALUOp  output  2  00 = add, 01 = sub, 10 = and, 11 = not(A).
REQ-010 done  output  1  one-cycle pulse on the final state of every instruction.

Function
REQ-011 The block SHALL be a Moore FSM; every output SHALL be a combinational function of the current state only, and SHALL be 0 in any state where it is not listed below.
REQ-012 Opcode map: 000 ADD, 001 SUB, 010 AND, 011 NOT, 100 PUSH addr, 101 POP addr, 110 JMP addr, 111 JZ addr.
REQ-013 FETCH SHALL assert memRead, IRWrite, srcA, srcB, pcWrite, with IorD=0, pcSrc=0 and ALUOp=00 (PC+1). Next state: DECODE.
REQ-014 DECODE SHALL assert nothing. It SHALL branch as follows: 000-011 to POP1, 100 to MEMRD, 101 to POPS, 110 to JMP, 111 to TOSZ.
REQ-015 POP1 SHALL assert tos, pop, ldA. Next state: EXEC if opcode is 011, otherwise POP2.
REQ-016 POP2 SHALL assert tos, pop, ldB. Next state: EXEC.
REQ-017 EXEC SHALL drive srcA=0, srcB=0 and ALUOp=opcode[1:0]. Next state: WBALU.
REQ-018 WBALU SHALL assert push and done, with MtoS=0. Next state: FETCH.
REQ-019 MEMRD SHALL assert IorD and memRead. Next state: WBMEM.
REQ-020 WBMEM SHALL assert push, MtoS and done. Next state: FETCH.
REQ-021 POPS SHALL assert tos, pop, ldA. Next state: MEMWR.
REQ-022 MEMWR SHALL assert IorD, memWrite and done. Next state: FETCH.
REQ-023 JMP SHALL assert pcSrc, pcWrite and done. Next state: FETCH.
REQ-024 TOSZ SHALL assert tos only, without pop, so the Z register captures the top of stack. Next state: JZBR.
REQ-025 JZBR SHALL assert pcSrc, pcWriteCond and done. Next state: FETCH.
REQ-026 Latency in cycles, including FETCH: ADD/SUB/AND = 6, NOT = 5, PUSH = 4, POP = 4, JMP = 3, JZ = 4.
REQ-027 Push and pop SHALL never be asserted in the same state.
REQ-028 memRead and memWrite SHALL never be asserted in the same state.
REQ-029 pcWrite and pcWriteCond SHALL never be asserted in the same state.
REQ-030 The state encoding SHALL be 4 bits. Any unused encoding SHALL transition to FETCH on the next edge with all outputs 0.
REQ-031 The block SHALL perform no stack full/empty checking; overflow and underflow behaviour is owned by the stack.

Reset
REQ-032 While rst=0 at a rising edge, the next state SHALL be FETCH; this applies in every state, including mid-instruction.
REQ-033 While rst=0, every output SHALL be forced to 0, including done.
REQ-034 The first cycle with rst=1 SHALL execute FETCH.
REQ-035 An instruction aborted by reset SHALL NOT be resumed; no partial push, pop or write continues after reset.

Verification
REQ-036 Release reset, opcode=000 -> state sequence FETCH, DECODE, POP1, POP2, EXEC(ALUOp=00), WBALU; push=1 and done=1 in cycle 6; FETCH in cycle 7.
REQ-037 opcode=011 -> POP1 goes directly to EXEC with ALUOp=11; done pulses in cycle 5; ldB is never asserted.
REQ-038 opcode=100, then opcode=101 -> MEMRD(IorD=1, memRead=1), WBMEM(push=1, MtoS=1); then POPS(pop=1, ldA=1), MEMWR(IorD=1, memWrite=1); each takes 4 cycles.
REQ-039 opcode=111 -> TOSZ has tos=1 and pop=0; JZBR has pcWriteCond=1, pcSrc=1, pcWrite=0. opcode=110 -> pcWrite=1 in cycle 3.
REQ-040 Assert rst=0 during POP2 of a SUB -> next state is FETCH and all outputs are 0 while rst=0; with rst=1, FETCH is output (IRWrite=1).
REQ-041 Every cycle of a random opcode stream SHALL satisfy the REQ-027 to REQ-029 exclusivity rules, and done SHALL pulse exactly once per instruction.

Source files
------------

// File: rtl/stack_cpu_controller.sv
// Multi-cycle control FSM for a small stack CPU: sequences fetch, decode,
// stack pops, ALU execute and write-back for an 8-opcode instruction set.
module stack_cpu_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       pcSrc,
  output logic       IorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       IRWrite,
  output logic       MtoS,
  output logic       ldA,
  output logic       ldB,
  output logic       srcA,
  output logic       srcB,
  output logic       push,
  output logic       pop,
  output logic       tos,
  output logic [1:0] ALUOp,
  output logic       done
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_POP1   = 4'd2,
    S_POP2   = 4'd3,
    S_EXEC   = 4'd4,
    S_WBALU  = 4'd5,
    S_MEMRD  = 4'd6,
    S_WBMEM  = 4'd7,
    S_POPS   = 4'd8,
    S_MEMWR  = 4'd9,
    S_JMP    = 4'd10,
    S_TOSZ   = 4'd11,
    S_JZBR   = 4'd12
  } state_t;

  state_t r_state;
  state_t w_next;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_FETCH;
    else      r_state <= w_next;
  end

  // Decode is gated by rst so every control line is held low during reset.
  always_comb begin
    w_next      = S_FETCH;
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    pcSrc       = 1'b0;
    IorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    IRWrite     = 1'b0;
    MtoS        = 1'b0;
    ldA         = 1'b0;
    ldB         = 1'b0;
    srcA        = 1'b0;
    srcB        = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    tos         = 1'b0;
    ALUOp       = 2'b00;
    done        = 1'b0;
    if (rst) begin
      case (r_state)
        S_FETCH: begin
          memRead = 1'b1;
          IRWrite = 1'b1;
          srcA    = 1'b1;
          srcB    = 1'b1;
          pcWrite = 1'b1;
          w_next  = S_DECODE;
        end
        S_DECODE: begin
          case (opcode)
            3'b100:  w_next = S_MEMRD;
            3'b101:  w_next = S_POPS;
            3'b110:  w_next = S_JMP;
            3'b111:  w_next = S_TOSZ;
            default: w_next = S_POP1;
          endcase
        end
        S_POP1: begin
          tos    = 1'b1;
          pop    = 1'b1;
          ldA    = 1'b1;
          w_next = (opcode == 3'b011) ? S_EXEC : S_POP2;
        end
        S_POP2: begin
          tos    = 1'b1;
          pop    = 1'b1;
          ldB    = 1'b1;
          w_next = S_EXEC;
        end
        S_EXEC: begin
          ALUOp  = opcode[1:0];
          w_next = S_WBALU;
        end
        S_WBALU: begin
          push   = 1'b1;
          done   = 1'b1;
          w_next = S_FETCH;
        end
        S_MEMRD: begin
          IorD    = 1'b1;
          memRead = 1'b1;
          w_next  = S_WBMEM;
        end
        S_WBMEM: begin
          push   = 1'b1;
          MtoS   = 1'b1;
          done   = 1'b1;
          w_next = S_FETCH;
        end
        S_POPS: begin
          tos    = 1'b1;
          pop    = 1'b1;
          ldA    = 1'b1;
          w_next = S_MEMWR;
        end
        S_MEMWR: begin
          IorD     = 1'b1;
          memWrite = 1'b1;
          done     = 1'b1;
          w_next   = S_FETCH;
        end
        S_JMP: begin
          pcSrc   = 1'b1;
          pcWrite = 1'b1;
          done    = 1'b1;
          w_next  = S_FETCH;
        end
        // Peek without pop so the zero flag sees the current top of stack.
        S_TOSZ: begin
          tos    = 1'b1;
          w_next = S_JZBR;
        end
        S_JZBR: begin
          pcSrc       = 1'b1;
          pcWriteCond = 1'b1;
          done        = 1'b1;
          w_next      = S_FETCH;
        end
        default: w_next = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_cpu_controller.sv
// Self-checking bench for stack_cpu_controller: per-instruction microstep
// model compared every cycle, plus latency, exclusivity and reset checks.
module tb_stack_cpu_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] opcode = 3'd0;
  logic pcWrite, pcWriteCond, pcSrc, IorD, memRead, memWrite, IRWrite, MtoS;
  logic ldA, ldB, srcA, srcB, push, pop, tos, done;
  logic [1:0] ALUOp;

  stack_cpu_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .pcSrc(pcSrc), .IorD(IorD),
    .memRead(memRead), .memWrite(memWrite), .IRWrite(IRWrite), .MtoS(MtoS),
    .ldA(ldA), .ldB(ldB), .srcA(srcA), .srcB(srcB),
    .push(push), .pop(pop), .tos(tos), .ALUOp(ALUOp), .done(done)
  );

  always #5 clk = ~clk;

  localparam logic [17:0] PCW   = 18'h20000;
  localparam logic [17:0] PCWC  = 18'h10000;
  localparam logic [17:0] PCSRC = 18'h08000;
  localparam logic [17:0] IORD  = 18'h04000;
  localparam logic [17:0] MRD   = 18'h02000;
  localparam logic [17:0] MWR   = 18'h01000;
  localparam logic [17:0] IRW   = 18'h00800;
  localparam logic [17:0] MTOS  = 18'h00400;
  localparam logic [17:0] LDA   = 18'h00200;
  localparam logic [17:0] LDB   = 18'h00100;
  localparam logic [17:0] SRCA  = 18'h00080;
  localparam logic [17:0] SRCB  = 18'h00040;
  localparam logic [17:0] PUSH  = 18'h00020;
  localparam logic [17:0] POP   = 18'h00010;
  localparam logic [17:0] TOS   = 18'h00008;
  localparam logic [17:0] DONE  = 18'h00001;

  logic [17:0] w_out;
  assign w_out = {pcWrite, pcWriteCond, pcSrc, IorD, memRead, memWrite, IRWrite,
                  MtoS, ldA, ldB, srcA, srcB, push, pop, tos, ALUOp, done};

  int total = 0;
  int bad = 0;
  int n_done = 0;
  int n_instr = 0;
  bit started = 1'b0;
  logic [17:0] exp_q[$];
  logic [17:0] first_word;
  logic [17:0] done_word;
  int lat_tab[8] = '{6, 6, 6, 5, 4, 4, 3, 4};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected output words, one per cycle, for a whole instruction.
  task automatic load_seq(input logic [2:0] op);
    exp_q.push_back(MRD | IRW | SRCA | SRCB | PCW);
    exp_q.push_back(18'd0);
    case (op)
      3'd0, 3'd1, 3'd2, 3'd3: begin
        exp_q.push_back(TOS | POP | LDA);
        if (op != 3'd3) exp_q.push_back(TOS | POP | LDB);
        exp_q.push_back({15'd0, op[1:0], 1'b0});
        exp_q.push_back(PUSH | DONE);
      end
      3'd4: begin
        exp_q.push_back(IORD | MRD);
        exp_q.push_back(PUSH | MTOS | DONE);
      end
      3'd5: begin
        exp_q.push_back(TOS | POP | LDA);
        exp_q.push_back(IORD | MWR | DONE);
      end
      3'd6: exp_q.push_back(PCSRC | PCW | DONE);
      default: begin
        exp_q.push_back(TOS);
        exp_q.push_back(PCSRC | PCWC | DONE);
      end
    endcase
  endtask

  always @(negedge clk) begin
    logic [17:0] exp;
    if (started) begin
      if (!rst) begin
        exp = 18'd0;
        exp_q.delete();
      end else begin
        if (exp_q.size() == 0) load_seq(opcode);
        exp = exp_q.pop_front();
      end
      chk("outputs", 32'(w_out), 32'(exp));
      chk("excl_push_pop", 32'(push & pop), 32'd0);
      chk("excl_mem_rw", 32'(memRead & memWrite), 32'd0);
      chk("excl_pcw", 32'(pcWrite & pcWriteCond), 32'd0);
      if (rst && done) n_done++;
    end
  end

  // Called one step after the edge that enters FETCH.
  task automatic run(input logic [2:0] op, input int lat);
    int n;
    opcode = op;
    n = 0;
    while (n < 12) begin
      @(negedge clk);
      n++;
      if (n == 1) first_word = w_out;
      if (done) break;
    end
    done_word = w_out;
    chk($sformatf("latency_op%0d", op), 32'(n), 32'(lat));
    n_instr++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] op;
    @(posedge clk);
    started = 1'b1;
    @(negedge clk);
    chk("reset_zero", 32'(w_out), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    run(3'd0, 6);
    chk("fetch_word", 32'(first_word), 32'h228C0);
    chk("add_done_word", 32'(done_word), 32'h00021);
    run(3'd3, 5);
    run(3'd4, 4);
    chk("push_done_word", 32'(done_word), 32'h00421);
    run(3'd5, 4);
    chk("pop_done_word", 32'(done_word), 32'h04001 | 32'h01000);
    run(3'd7, 4);
    chk("jz_done_word", 32'(done_word), 32'h18001);
    run(3'd6, 3);
    chk("jmp_done_word", 32'(done_word), 32'h28001);
    run(3'd1, 6);
    run(3'd2, 6);

    // Abort a SUB in POP2 and confirm a clean refetch.
    opcode = 3'd1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_zero", 32'(w_out), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    run(3'd2, 6);
    chk("rst_refetch_irw", 32'(first_word[11]), 32'd1);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      run(op, lat_tab[op]);
    end
    chk("done_count", 32'(n_done), 32'(n_instr));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
